// File: rtl/fft_stage0_sdf_buf_if.sv
// Signal bundle between the stage-0 SDF buffer, its upstream source,
// the external radix-2 butterfly and the downstream sink.
interface fft_stage0_sdf_buf_if #(
   parameter int WIDTH      = 9,
   parameter int DATA_WIDTH = 16
);
   logic                               din_valid;
   logic                               din_ready;
   logic [DATA_WIDTH-1:0][WIDTH-1:0]   din_re;
   logic [DATA_WIDTH-1:0][WIDTH-1:0]   din_im;
   logic                               flush;

   logic [DATA_WIDTH-1:0][WIDTH-1:0]   sr_re;
   logic [DATA_WIDTH-1:0][WIDTH-1:0]   sr_im;
   logic                               fac8_0_cal;
   logic [DATA_WIDTH-1:0][WIDTH:0]     bf_add_re;
   logic [DATA_WIDTH-1:0][WIDTH:0]     bf_add_im;
   logic [DATA_WIDTH-1:0][WIDTH:0]     bf_sub_re;
   logic [DATA_WIDTH-1:0][WIDTH:0]     bf_sub_im;

   logic                               dout_valid;
   logic                               dout_sop;
   logic [DATA_WIDTH-1:0][WIDTH:0]     dout_re;
   logic [DATA_WIDTH-1:0][WIDTH:0]     dout_im;

   modport master (
      output din_valid, din_re, din_im, flush,
      output bf_add_re, bf_add_im, bf_sub_re, bf_sub_im,
      input  din_ready, sr_re, sr_im, fac8_0_cal,
      input  dout_valid, dout_sop, dout_re, dout_im
   );

   modport slave (
      input  din_valid, din_re, din_im, flush,
      input  bf_add_re, bf_add_im, bf_sub_re, bf_sub_im,
      output din_ready, sr_re, sr_im, fac8_0_cal,
      output dout_valid, dout_sop, dout_re, dout_im
   );
endinterface

// File: rtl/fft_stage0_sdf_buf.sv
// FFT stage-0 single-path delay-feedback buffer: stores the first half-frame,
// feeds the external butterfly, streams add results and recirculates subs.
module fft_stage0_sdf_buf #(
   parameter int WIDTH      = 9,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   fft_stage0_sdf_buf_if.slave  bus
);
   localparam int               CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DEPTH / 2);

   typedef logic [DATA_WIDTH-1:0][WIDTH-1:0] in_vec_t;
   typedef logic [DATA_WIDTH-1:0][WIDTH:0]   wide_vec_t;
   typedef enum logic [1:0] {FILL = 2'd0, BFLY = 2'd1, DRAIN = 2'd2} state_t;

   function automatic wide_vec_t sext_vec(input in_vec_t v);
      wide_vec_t r;
      for (int l = 0; l < DATA_WIDTH; l++) begin
         r[l] = {v[l][WIDTH-1], v[l]};
      end
      return r;
   endfunction

   function automatic in_vec_t low_vec(input wide_vec_t v);
      in_vec_t r;
      for (int l = 0; l < DATA_WIDTH; l++) begin
         r[l] = v[l][WIDTH-1:0];
      end
      return r;
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_pending;
   logic             w_pending_nxt;

   wide_vec_t        r_line_re [DEPTH];
   wide_vec_t        r_line_im [DEPTH];

   wide_vec_t        r_dout_re;
   wide_vec_t        r_dout_im;
   logic             r_dout_valid;
   logic             r_dout_sop;

   logic             w_last;
   logic             w_drain_entry;
   logic             w_din_ready;
   logic             w_accept;
   logic             w_shift;
   logic             w_out_valid;
   wide_vec_t        w_push_re;
   wide_vec_t        w_push_im;
   wide_vec_t        w_out_re;
   wide_vec_t        w_out_im;

   assign w_last        = (r_cnt == CNT_LAST);
   // Flush wins over din_valid at the half-frame boundary, so input is refused that cycle.
   assign w_drain_entry = (r_state == FILL) && (r_cnt == '0) && r_pending && bus.flush;
   assign w_din_ready   = (r_state != DRAIN) && !w_drain_entry;
   assign w_accept      = bus.din_valid && w_din_ready;

   assign bus.din_ready  = w_din_ready;
   assign bus.sr_re      = low_vec(r_line_re[0]);
   assign bus.sr_im      = low_vec(r_line_im[0]);
   assign bus.fac8_0_cal = (r_state == BFLY) && (r_cnt >= CNT_HALF);

   assign bus.dout_valid = r_dout_valid;
   assign bus.dout_sop   = r_dout_sop;
   assign bus.dout_re    = r_dout_re;
   assign bus.dout_im    = r_dout_im;

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_pending_nxt = r_pending;
      w_shift       = 1'b0;
      w_out_valid   = 1'b0;
      w_push_re     = '0;
      w_push_im     = '0;
      w_out_re      = r_line_re[0];
      w_out_im      = r_line_im[0];
      unique case (r_state)
         FILL: begin
            if (w_drain_entry) begin
               w_state_nxt = DRAIN;
            end else if (w_accept) begin
               w_shift     = 1'b1;
               w_push_re   = sext_vec(bus.din_re);
               w_push_im   = sext_vec(bus.din_im);
               w_out_valid = r_pending;
               if (w_last) begin
                  w_state_nxt = BFLY;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = r_cnt + 1'b1;
               end
            end
         end
         BFLY: begin
            if (w_accept) begin
               w_shift     = 1'b1;
               w_push_re   = bus.bf_sub_re;
               w_push_im   = bus.bf_sub_im;
               w_out_re    = bus.bf_add_re;
               w_out_im    = bus.bf_add_im;
               w_out_valid = 1'b1;
               if (w_last) begin
                  w_state_nxt   = FILL;
                  w_cnt_nxt     = '0;
                  w_pending_nxt = 1'b1;
               end else begin
                  w_cnt_nxt     = r_cnt + 1'b1;
               end
            end
         end
         DRAIN: begin
            // Zeros refill the line so a later FILL without pending pops nothing stale.
            w_shift     = 1'b1;
            w_out_valid = 1'b1;
            if (w_last) begin
               w_state_nxt   = FILL;
               w_cnt_nxt     = '0;
               w_pending_nxt = 1'b0;
            end else begin
               w_cnt_nxt     = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = FILL;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= FILL;
         r_cnt     <= '0;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_line_re[i] <= '0;
            r_line_im[i] <= '0;
         end
      end else if (w_shift) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            r_line_re[i] <= r_line_re[i+1];
            r_line_im[i] <= r_line_im[i+1];
         end
         r_line_re[DEPTH-1] <= w_push_re;
         r_line_im[DEPTH-1] <= w_push_im;
      end
   end

   // Output register: loads on every shift, holds its data across stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout_valid <= 1'b0;
         r_dout_sop   <= 1'b0;
         r_dout_re    <= '0;
         r_dout_im    <= '0;
      end else if (w_shift) begin
         r_dout_valid <= w_out_valid;
         r_dout_sop   <= w_out_valid && (r_cnt == '0);
         r_dout_re    <= w_out_re;
         r_dout_im    <= w_out_im;
      end else begin
         r_dout_valid <= 1'b0;
         r_dout_sop   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fft_stage0_sdf_buf.sv
// Bench for fft_stage0_sdf_buf: ramp-frame vector table, flush/reset sequences,
// and randomized traffic checked against a frame-level reference model.
module tb_fft_stage0_sdf_buf;
   localparam int W  = 9;
   localparam int DW = 16;
   localparam int D  = 16;

   typedef logic [DW-1:0][W-1:0] ivec_t;
   typedef logic [DW-1:0][W:0]   ovec_t;
   typedef struct {
      int din;
      bit e_valid;
      bit e_sop;
      int e_re;
      int e_im;
      bit e_fac;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fft_stage0_sdf_buf_if #(.WIDTH(W), .DATA_WIDTH(DW)) bus ();

   fft_stage0_sdf_buf #(.WIDTH(W), .DATA_WIDTH(DW), .DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic signed [W:0] sx(input logic [W-1:0] v);
      return {v[W-1], v};
   endfunction

   // Radix-2 butterfly: add = sr + din, sub = (sr - din) times -j when fac8_0_cal.
   always_comb begin
      bus.bf_add_re = '0;
      bus.bf_add_im = '0;
      bus.bf_sub_re = '0;
      bus.bf_sub_im = '0;
      for (int l = 0; l < DW; l++) begin
         bus.bf_add_re[l] = sx(bus.sr_re[l]) + sx(bus.din_re[l]);
         bus.bf_add_im[l] = sx(bus.sr_im[l]) + sx(bus.din_im[l]);
         if (bus.fac8_0_cal) begin
            bus.bf_sub_re[l] = sx(bus.sr_im[l]) - sx(bus.din_im[l]);
            bus.bf_sub_im[l] = sx(bus.din_re[l]) - sx(bus.sr_re[l]);
         end else begin
            bus.bf_sub_re[l] = sx(bus.sr_re[l]) - sx(bus.din_re[l]);
            bus.bf_sub_im[l] = sx(bus.sr_im[l]) - sx(bus.din_im[l]);
         end
      end
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkv(input string nm, input ovec_t act, input ovec_t exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic ivec_t irep(input int v);
      ivec_t r;
      for (int l = 0; l < DW; l++) r[l] = W'(v);
      return r;
   endfunction

   function automatic ovec_t orep(input int v);
      ovec_t r;
      for (int l = 0; l < DW; l++) r[l] = (W+1)'(v);
      return r;
   endfunction

   function automatic ivec_t irand();
      ivec_t r;
      for (int l = 0; l < DW; l++) begin
         case ($urandom_range(0, 7))
            0:       r[l] = W'(-256);
            1:       r[l] = W'(255);
            default: r[l] = W'($urandom_range(0, 511));
         endcase
      end
      return r;
   endfunction

   task automatic drive(input bit v, input bit f, input ivec_t re, input ivec_t im);
      bus.din_valid = v;
      bus.flush     = f;
      bus.din_re    = re;
      bus.din_im    = im;
   endtask

   // Frame-level reference model: position in frame, stored first half, pending subs.
   int    m_pos;
   bit    m_pending;
   bit    m_draining;
   int    m_didx;
   ivec_t m_first_re [D];
   ivec_t m_first_im [D];
   ovec_t m_sub_re   [D];
   ovec_t m_sub_im   [D];

   bit    e_valid;
   bit    e_sop;
   ovec_t e_re;
   ovec_t e_im;
   logic  s_ready;
   logic  s_fac;

   task automatic model_reset();
      m_pos      = 0;
      m_pending  = 1'b0;
      m_draining = 1'b0;
      m_didx     = 0;
   endtask

   // One clock: called at a negedge with inputs already driven; returns at the next negedge.
   task automatic tick();
      int   k, fr, fi, xr, xi;
      logic exp_ready, exp_fac;
      #1;
      exp_ready = !m_draining && !(m_pos == 0 && m_pending && bus.flush);
      exp_fac   = !m_draining && (m_pos >= D + D/2);
      s_ready   = bus.din_ready;
      s_fac     = bus.fac8_0_cal;
      chk1("din_ready", s_ready, exp_ready);
      chk1("fac8_0_cal", s_fac, exp_fac);
      e_valid = 1'b0;
      e_sop   = 1'b0;
      e_re    = '0;
      e_im    = '0;
      if (m_draining) begin
         e_valid = 1'b1;
         e_sop   = (m_didx == 0);
         e_re    = m_sub_re[m_didx];
         e_im    = m_sub_im[m_didx];
         m_didx++;
         if (m_didx == D) begin
            m_draining = 1'b0;
            m_pending  = 1'b0;
         end
      end else if (!exp_ready) begin
         m_draining = 1'b1;
         m_didx     = 0;
      end else if (bus.din_valid) begin
         if (m_pos < D) begin
            m_first_re[m_pos] = bus.din_re;
            m_first_im[m_pos] = bus.din_im;
            if (m_pending) begin
               e_valid = 1'b1;
               e_sop   = (m_pos == 0);
               e_re    = m_sub_re[m_pos];
               e_im    = m_sub_im[m_pos];
            end
         end else begin
            k = m_pos - D;
            for (int l = 0; l < DW; l++) begin
               fr = int'($signed(m_first_re[k][l]));
               fi = int'($signed(m_first_im[k][l]));
               xr = int'($signed(bus.din_re[l]));
               xi = int'($signed(bus.din_im[l]));
               e_re[l] = (W+1)'(fr + xr);
               e_im[l] = (W+1)'(fi + xi);
               if (k >= D/2) begin
                  m_sub_re[k][l] = (W+1)'(fi - xi);
                  m_sub_im[k][l] = (W+1)'(xr - fr);
               end else begin
                  m_sub_re[k][l] = (W+1)'(fr - xr);
                  m_sub_im[k][l] = (W+1)'(fi - xi);
               end
            end
            e_valid = 1'b1;
            e_sop   = (k == 0);
            if (k == D - 1) m_pending = 1'b1;
         end
         m_pos = (m_pos + 1) % (2 * D);
      end
      @(posedge clk);
      @(negedge clk);
      chk1("dout_valid", bus.dout_valid, e_valid);
      chk1("dout_sop", bus.dout_sop, e_sop);
      if (e_valid) begin
         chkv("dout_re", bus.dout_re, e_re);
         chkv("dout_im", bus.dout_im, e_im);
      end
   endtask

   rec_t tbl [96];

   initial begin
      // Three back-to-back ramp frames: re of vector m = m, im = 0.
      for (int i = 0; i < 96; i++) begin
         int f, m;
         f = i / 32;
         m = i % 32;
         tbl[i].din   = m;
         tbl[i].e_fac = (m >= 24);
         if (m >= 16) begin
            tbl[i].e_valid = 1'b1;
            tbl[i].e_sop   = (m == 16);
            tbl[i].e_re    = 2 * m - 16;
            tbl[i].e_im    = 0;
         end else if (f == 0) begin
            tbl[i].e_valid = 1'b0;
            tbl[i].e_sop   = 1'b0;
            tbl[i].e_re    = 0;
            tbl[i].e_im    = 0;
         end else begin
            tbl[i].e_valid = 1'b1;
            tbl[i].e_sop   = (m == 0);
            tbl[i].e_re    = (m < 8) ? -16 : 0;
            tbl[i].e_im    = (m < 8) ? 0 : 16;
         end
      end

      drive(1'b0, 1'b0, '0, '0);
      model_reset();
      @(negedge clk);
      chk1("reset_valid", bus.dout_valid, 1'b0);
      chk1("reset_sop", bus.dout_sop, 1'b0);
      chkv("reset_re", bus.dout_re, '0);
      chkv("reset_im", bus.dout_im, '0);
      chk1("reset_ready", bus.din_ready, 1'b1);
      chk1("reset_fac", bus.fac8_0_cal, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 96; i++) begin
         drive(1'b1, 1'b0, irep(tbl[i].din), '0);
         tick();
         chk1("tbl_fac", s_fac, tbl[i].e_fac);
         chk1("tbl_valid", bus.dout_valid, tbl[i].e_valid);
         if (tbl[i].e_valid) begin
            chk1("tbl_sop", bus.dout_sop, tbl[i].e_sop);
            chkv("tbl_re", bus.dout_re, orep(tbl[i].e_re));
            chkv("tbl_im", bus.dout_im, orep(tbl[i].e_im));
         end
      end

      // Flush and din_valid together at the boundary: drain wins, din refused.
      drive(1'b1, 1'b1, irep(99), '0);
      tick();
      chk1("flush_entry_ready", s_ready, 1'b0);
      chk1("flush_entry_valid", bus.dout_valid, 1'b0);
      for (int i = 0; i < D; i++) begin
         drive(1'b1, 1'b0, irep(77), '0);
         tick();
         chk1("drain_ready", s_ready, 1'b0);
         chk1("drain_valid", bus.dout_valid, 1'b1);
         chk1("drain_sop", bus.dout_sop, i == 0);
         chkv("drain_re", bus.dout_re, orep((i < 8) ? -16 : 0));
         chkv("drain_im", bus.dout_im, orep((i < 8) ? 0 : 16));
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, '0, '0);
         tick();
         chk1("post_drain_ready", s_ready, 1'b1);
         chk1("post_drain_valid", bus.dout_valid, 1'b0);
      end
      drive(1'b1, 1'b1, irand(), irand());
      tick();
      chk1("flush_ignored_ready", s_ready, 1'b1);

      // Advance into BFLY, then pulse reset away from the clock edge.
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, irand(), irand());
         tick();
      end
      chk1("pre_rst_valid", bus.dout_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk1("async_rst_valid", bus.dout_valid, 1'b0);
      chk1("async_rst_sop", bus.dout_sop, 1'b0);
      chkv("async_rst_re", bus.dout_re, '0);
      chkv("async_rst_im", bus.dout_im, '0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk1("post_rst_ready", bus.din_ready, 1'b1);
      chk1("post_rst_fac", bus.fac8_0_cal, 1'b0);

      for (int i = 0; i < 900; i++) begin
         drive(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), irand(), irand());
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
